ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Accepts a decoded instruction from ID over a valid/ready handshake and resolves operand forwarding from MEM/WB.
- Drives operand_a, operand_b and alu_op to the ALU and holds them for a per-op multicycle window, because the combinational multiplier and divider paths are long.
- Captures alu_data into a result register and presents it to EX/MEM over valid/ready.

Parameters:
MUL_LAT, 2, cycles the operands are held for alu_op 01010..01101 (MUL, MULH, MULHU, MULHSU); legal range 1..15.
DIV_LAT, 4, cycles the operands are held for alu_op 01110..10001 (DIVU, REMU, DIV, REM); legal range 1..15.

Ports:
clk  in  1  clock; one clock domain.
rst_n  in  1  reset; asynchronous, active-low.
flush  in  1  synchronous pipeline flush (branch mispredict or trap).
id_valid  in  1  ID holds a valid instruction.
id_ready  out  1  stage can accept this cycle.
id_alu_op  in  5  ALU operation code.
id_rs1_addr, id_rs2_addr  in  5 each  source register indices.
id_rs1_data, id_rs2_data  in  32 each  register-file read data.
id_pc  in  32  instruction PC.
id_imm  in  32  sign-extended immediate.
id_use_pc  in  1  operand A = PC.
id_use_imm  in  1  operand B = immediate.
id_rd_addr  in  5  destination register.
id_rd_wren  in  1  destination write enable.
mem_rd_addr, wb_rd_addr  in  5 each  forwarding source destinations.
mem_rd_wren, wb_rd_wren  in  1 each  forwarding source enables.
mem_rd_data, wb_rd_data  in  32 each  forwarding source data.
operand_a, operand_b  out  32 each  to ALU; registered.
alu_op  out  5  to ALU; registered.
alu_data  in  32  ALU combinational result.
ex_valid  out  1  result valid toward EX/MEM.
ex_ready  in  1  EX/MEM accepts.
ex_alu_data  out  32  registered result.
ex_rd_addr  out  5  registered destination.
ex_rd_wren  out  1  registered write enable.
busy  out  1  high in EXEC.

Behaviour:
Reset:
- rst_n low immediately forces state IDLE and clears every output register to 0: operand_a, operand_b, alu_op, ex_*, cnt.
- busy = 0 and ex_valid = 0 during reset.

Forwarding (combinational at accept):
- For rsX, select mem_rd_data if mem_rd_wren && mem_rd_addr==rsX && rsX!=0.
- Otherwise wb_rd_data under the same conditions on the WB port.
- Otherwise id_rsX_data.
- MEM has priority over WB. x0 is never forwarded.
- operand_a = id_use_pc ? id_pc : fwd_rs1.
- operand_b = id_use_imm ? id_imm : fwd_rs2.

Latency class (L):
- L = MUL_LAT for the MUL group.
- L = DIV_LAT for the DIV group.
- L = 1 for all other codes, including undefined codes 10010..11111.

States:
- IDLE: no instruction held; ex_valid = 0.
- EXEC: operands held stable on ALU inputs; cnt counts down from L.
- DONE: result held; ex_valid = 1.

Handshake and transitions:
- id_ready = !flush && (state==IDLE || (state==DONE && ex_ready)).
- Accept = id_valid && id_ready. On accept: register operands, alu_op and rd fields; cnt <= L; go to EXEC.
- EXEC: cnt decrements each cycle. In the cycle where cnt==1, alu_data, rd_addr and rd_wren are captured into ex_* at the clock edge, then state goes to DONE.
- Operands and alu_op must not change while in EXEC.
- DONE with ex_ready:
  - On accept: go to EXEC (back-to-back, no bubble).
  - Otherwise: go to IDLE and drop ex_valid.
- DONE without ex_ready: hold. ex_alu_data, ex_rd_addr and ex_rd_wren stay stable while ex_valid && !ex_ready.
- Timing: accept edge at cycle 0, ex_valid first high in cycle L+1. With ex_ready held high, sustained throughput is one instruction per L+1 cycles.

Flush:
- Highest priority below reset. At the next edge: state to IDLE, ex_valid to 0, cnt to 0.
- Any in-flight or held result is discarded, including a result being handshaken that cycle.
- id_ready is 0 during the flush cycle, so no instruction is accepted.

Other rules:
- No result-value arithmetic is done here. Divide-by-zero and overflow results are whatever the ALU returns.
- ex_rd_wren is passed through unmodified. For rd=0, the regfile ignores the write.

Test Plan:
- ADD, forwarding: rs1=5 with id 0x10; MEM forwards rd=5 = 0x100; WB forwards rd=5 = 0x200; rs2 data 0x1; alu_op 00000 -> operand_a=0x100, ex_valid in cycle 2, ex_alu_data=0x101. Repeat with rs1=0 and MEM rd=0 -> operand_a=0.
- DIV latency: DIV_LAT=4, DIV 0xFFFFFFF9 / 2 -> operands stable for 4 cycles, busy=1, ex_valid in cycle 5, ex_alu_data=0xFFFFFFFD, id_ready=0 in cycles 1-4.
- Back-pressure: MUL 3*7 with ex_ready=0 for 3 cycles after ex_valid -> ex_alu_data=21 stable and id_ready=0; raising ex_ready with id_valid=1 -> next op accepted in the same cycle, no bubble.
- Flush: issue DIVU, assert flush in cycle 2 -> ex_valid never rises, state IDLE, id_ready=1 in cycle 4; flush with ex_valid=1 && ex_ready=1 -> no accept that cycle.
- Async reset: drop rst_n mid-EXEC, off-edge -> all outputs 0 immediately; release -> IDLE, id_ready=1.
- Immediate/PC select: id_use_pc=1 with id_pc=0x80, id_use_imm=1 with id_imm=0xFFFFFFFC, ADD -> ex_alu_data=0x7C; undefined alu_op 11111 -> L=1.

Source files
------------

// File: rtl/ex_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_issue_stage: ID/EX stage that holds ALU operands for a per-op window   |
// | and registers the ALU result toward EX/MEM. Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module ex_issue_stage #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_alu_op,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_imm,
  input  logic        id_use_pc,
  input  logic        id_use_imm,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_wren,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_rd_wren,
  input  logic [31:0] mem_rd_data,
  input  logic [4:0]  wb_rd_addr,
  input  logic        wb_rd_wren,
  input  logic [31:0] wb_rd_data,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_alu_data,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_rd_wren,
  output logic        busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [3:0] c_MUL_LAT = 4'(MUL_LAT);
  localparam logic [3:0] c_DIV_LAT = 4'(DIV_LAT);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_lat;
  logic        w_accept;
  logic        w_last;
  logic [31:0] w_fwd_rs1;
  logic [31:0] w_fwd_rs2;

  assign w_accept = id_valid && id_ready;
  assign w_last   = (r_state == c_EXEC) && (r_cnt == 4'd1);

  // MEM is the younger producer, so it wins over WB; x0 is hardwired zero.
  always_comb begin
    w_fwd_rs1 = id_rs1_data;
    if (mem_rd_wren && (mem_rd_addr == id_rs1_addr) && (id_rs1_addr != 5'd0))
      w_fwd_rs1 = mem_rd_data;
    else if (wb_rd_wren && (wb_rd_addr == id_rs1_addr) && (id_rs1_addr != 5'd0))
      w_fwd_rs1 = wb_rd_data;
  end

  always_comb begin
    w_fwd_rs2 = id_rs2_data;
    if (mem_rd_wren && (mem_rd_addr == id_rs2_addr) && (id_rs2_addr != 5'd0))
      w_fwd_rs2 = mem_rd_data;
    else if (wb_rd_wren && (wb_rd_addr == id_rs2_addr) && (id_rs2_addr != 5'd0))
      w_fwd_rs2 = wb_rd_data;
  end

  always_comb begin
    w_lat = 4'd1;
    if ((id_alu_op >= 5'd10) && (id_alu_op <= 5'd13))
      w_lat = c_MUL_LAT;
    else if ((id_alu_op >= 5'd14) && (id_alu_op <= 5'd17))
      w_lat = c_DIV_LAT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= c_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE: if (w_accept) w_state_nxt = c_EXEC;
        c_EXEC: if (r_cnt == 4'd1) w_state_nxt = c_DONE;
        c_DONE: if (ex_ready) w_state_nxt = w_accept ? c_EXEC : c_IDLE;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    id_ready = !flush && ((r_state == c_IDLE) || ((r_state == c_DONE) && ex_ready));
    ex_valid = (r_state == c_DONE);
    busy     = (r_state == c_EXEC);
  end

  // Operands only load on accept, which is impossible while in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_a <= 32'd0;
      operand_b <= 32'd0;
      alu_op    <= 5'd0;
    end else if (w_accept) begin
      operand_a <= id_use_pc  ? id_pc  : w_fwd_rs1;
      operand_b <= id_use_imm ? id_imm : w_fwd_rs2;
      alu_op    <= id_alu_op;
    end
  end

  logic [4:0] r_rd_addr;
  logic       r_rd_wren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr <= 5'd0;
      r_rd_wren <= 1'b0;
    end else if (w_accept) begin
      r_rd_addr <= id_rd_addr;
      r_rd_wren <= id_rd_wren;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= 4'd0;
    else if (flush)
      r_cnt <= 4'd0;
    else if (w_accept)
      r_cnt <= w_lat;
    else if (r_state == c_EXEC)
      r_cnt <= r_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_alu_data <= 32'd0;
      ex_rd_addr  <= 5'd0;
      ex_rd_wren  <= 1'b0;
    end else if (!flush && w_last) begin
      ex_alu_data <= alu_data;
      ex_rd_addr  <= r_rd_addr;
      ex_rd_wren  <= r_rd_wren;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// Bench for ex_issue_stage: directed cases plus randomized traffic, checked
// by a scoreboard against a transaction-level model of the stage.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [4:0]  id_alu_op = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0;
  logic [31:0] id_rs1_data = '0, id_rs2_data = '0;
  logic [31:0] id_pc = '0, id_imm = '0;
  logic        id_use_pc = 1'b0, id_use_imm = 1'b0;
  logic [4:0]  id_rd_addr = '0;
  logic        id_rd_wren = 1'b0;
  logic [4:0]  mem_rd_addr = '0, wb_rd_addr = '0;
  logic        mem_rd_wren = 1'b0, wb_rd_wren = 1'b0;
  logic [31:0] mem_rd_data = '0, wb_rd_data = '0;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wren;
  logic        busy;

  logic bp_mode = 1'b0;
  logic rnd_ready = 1'b1;
  logic man_ready = 1'b1;
  assign ex_ready = bp_mode ? rnd_ready : man_ready;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  localparam int MUL_L = 2;
  localparam int DIV_L = 4;

  // Bench-side ALU, RISC-V M-extension semantics for the multi-cycle groups.
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] op);
    logic [63:0] p;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd10: begin p = 64'(a) * 64'(b); return p[31:0]; end
      5'd11: begin p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})); return p[63:32]; end
      5'd12: begin p = 64'(a) * 64'(b); return p[63:32]; end
      5'd13: begin p = 64'($signed({{32{a[31]}}, a}) * $signed({32'd0, b})); return p[63:32]; end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd15: return (b == 0) ? a : a % b;
      5'd16: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      5'd17: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return a ^ b ^ {27'd0, op};
    endcase
  endfunction

  assign alu_data = alu_fn(operand_a, operand_b, alu_op);

  ex_issue_stage #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_op(id_alu_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_pc(id_pc), .id_imm(id_imm), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_rd_addr(id_rd_addr), .id_rd_wren(id_rd_wren),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren), .mem_rd_data(mem_rd_data),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren), .wb_rd_data(wb_rd_data),
    .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op), .alu_data(alu_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_data(ex_alu_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a, b, res;
    logic [4:0]  op, rd;
    logic        wren;
    int          due;
  } exp_t;
  exp_t q[$];

  function automatic logic [31:0] ref_fwd(logic [4:0] rs, logic [31:0] rf);
    if (rs == 0) return rf;
    if (mem_rd_wren && mem_rd_addr == rs) return mem_rd_data;
    if (wb_rd_wren && wb_rd_addr == rs) return wb_rd_data;
    return rf;
  endfunction

  function automatic int ref_lat(logic [4:0] op);
    int o = int'(op);
    if (o >= 10 && o <= 13) return MUL_L;
    if (o >= 14 && o <= 17) return DIV_L;
    return 1;
  endfunction

  // Monitor / scoreboard: one instruction in flight at most; the result is
  // due L+1 cycles after the accepting edge and stays until handshaken.
  initial begin
    logic ev, eb, er;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        continue;
      end
      ev = (q.size() > 0) && (cyc >= q[0].due);
      eb = (q.size() > 0) && !ev;
      er = !flush && ((q.size() == 0) || (ev && ex_ready));
      check("ex_valid", 32'(ex_valid), 32'(ev));
      check("busy", 32'(busy), 32'(eb));
      check("id_ready", 32'(id_ready), 32'(er));
      if (ev) begin
        check("ex_alu_data", ex_alu_data, q[0].res);
        check("ex_rd_addr", 32'(ex_rd_addr), 32'(q[0].rd));
        check("ex_rd_wren", 32'(ex_rd_wren), 32'(q[0].wren));
      end
      if (eb) begin
        check("operand_a", operand_a, q[0].a);
        check("operand_b", operand_b, q[0].b);
        check("alu_op", 32'(alu_op), 32'(q[0].op));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ev && ex_ready) void'(q.pop_front());
        if (id_valid && er) begin
          e.a    = id_use_pc  ? id_pc  : ref_fwd(id_rs1_addr, id_rs1_data);
          e.b    = id_use_imm ? id_imm : ref_fwd(id_rs2_addr, id_rs2_data);
          e.op   = id_alu_op;
          e.res  = alu_fn(e.a, e.b, e.op);
          e.rd   = id_rd_addr;
          e.wren = id_rd_wren;
          e.due  = cyc + ref_lat(e.op) + 1;
          q.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send();
    int n = 0;
    id_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (id_ready) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL send_timeout at cycle %0d: id_ready stuck low", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ex_valid && n < 60);
    if (!ex_valid) begin
      total++; bad++;
      $display("FAIL wait_valid_timeout at cycle %0d: ex_valid 0 expected 1", cyc);
    end
  endtask

  task automatic set_instr(logic [4:0] op, logic [4:0] r1, logic [31:0] d1,
                           logic [4:0] r2, logic [31:0] d2);
    id_alu_op = op; id_rs1_addr = r1; id_rs1_data = d1;
    id_rs2_addr = r2; id_rs2_data = d2;
    id_use_pc = 1'b0; id_use_imm = 1'b0;
    id_rd_addr = 5'd9; id_rd_wren = 1'b1;
    mem_rd_wren = 1'b0; wb_rd_wren = 1'b0;
  endtask

  task automatic rand_instr();
    logic [4:0] pool [3];
    id_alu_op   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
    id_rs1_addr = 5'($urandom_range(0, 7));
    id_rs2_addr = 5'($urandom_range(0, 7));
    id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_pc = $urandom; id_imm = $urandom;
    id_use_pc  = ($urandom_range(0, 3) == 0);
    id_use_imm = ($urandom_range(0, 3) == 0);
    id_rd_addr = 5'($urandom_range(0, 31));
    id_rd_wren = 1'($urandom_range(0, 1));
    pool[0] = id_rs1_addr; pool[1] = id_rs2_addr; pool[2] = 5'($urandom_range(0, 7));
    mem_rd_addr = pool[$urandom_range(0, 2)];
    wb_rd_addr  = pool[$urandom_range(0, 2)];
    mem_rd_wren = 1'($urandom_range(0, 1));
    wb_rd_wren  = 1'($urandom_range(0, 1));
    mem_rd_data = $urandom; wb_rd_data = $urandom;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_operand_a", operand_a, 32'd0);
    check("rst_operand_b", operand_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ex_alu_data", ex_alu_data, 32'd0);
    rst_n = 1'b1;

    // ADD with MEM-over-WB forwarding on rs1
    set_instr(5'd0, 5'd5, 32'h10, 5'd6, 32'h1);
    mem_rd_addr = 5'd5; mem_rd_wren = 1'b1; mem_rd_data = 32'h100;
    wb_rd_addr  = 5'd5; wb_rd_wren  = 1'b1; wb_rd_data  = 32'h200;
    send();
    wait_valid(n);
    check("add_fwd_latency", 32'(n), 32'd2);
    check("add_fwd_opa", operand_a, 32'h100);
    check("add_fwd_result", ex_alu_data, 32'h101);
    @(posedge clk); #1;

    // x0 is never forwarded
    set_instr(5'd0, 5'd0, 32'h0, 5'd6, 32'h1);
    mem_rd_addr = 5'd0; mem_rd_wren = 1'b1; mem_rd_data = 32'hDEAD;
    send();
    wait_valid(n);
    check("x0_opa", operand_a, 32'h0);
    @(posedge clk); #1;

    // signed divide holds operands for DIV_LAT cycles
    set_instr(5'd16, 5'd1, 32'hFFFF_FFF9, 5'd2, 32'd2);
    send();
    wait_valid(n);
    check("div_latency", 32'(n), 32'(DIV_L + 1));
    check("div_result", ex_alu_data, 32'hFFFF_FFFD);
    @(posedge clk); #1;

    // back-pressure on a multiply, then no-bubble accept on release
    man_ready = 1'b0;
    set_instr(5'd10, 5'd1, 32'd3, 5'd2, 32'd7);
    send();
    wait_valid(n);
    set_instr(5'd1, 5'd3, 32'd50, 5'd4, 32'd8);
    id_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_data", ex_alu_data, 32'd21);
      check("bp_id_ready", 32'(id_ready), 32'd0);
    end
    @(posedge clk); #1;
    man_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(id_ready), 32'd1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    wait_valid(n);
    check("b2b_result", ex_alu_data, 32'd42);
    @(posedge clk); #1;

    // flush mid-EXEC discards the divide
    set_instr(5'd14, 5'd1, 32'd100, 5'd2, 32'd7);
    send();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_idle_ready", 32'(id_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("flush_no_valid", 32'(ex_valid), 32'd0);
    end
    @(posedge clk); #1;

    // flush during a result handshake blocks acceptance
    man_ready = 1'b0;
    set_instr(5'd2, 5'd1, 32'hF0F0, 5'd2, 32'hFF00);
    send();
    wait_valid(n);
    @(posedge clk); #1;
    flush = 1'b1; man_ready = 1'b1; id_valid = 1'b1;
    @(negedge clk);
    check("flush_hs_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    check("flush_hs_valid", 32'(ex_valid), 32'd0);
    check("flush_hs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // asynchronous reset mid-EXEC
    set_instr(5'd16, 5'd1, 32'h1234, 5'd2, 32'd5);
    send();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_operand_a", operand_a, 32'd0);
    check("arst_operand_b", operand_b, 32'd0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ex_valid", 32'(ex_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_ready", 32'(id_ready), 32'd1);
    @(posedge clk); #1;

    // PC / immediate select
    set_instr(5'd0, 5'd1, 32'h5555, 5'd2, 32'h6666);
    id_use_pc = 1'b1; id_pc = 32'h80;
    id_use_imm = 1'b1; id_imm = 32'hFFFF_FFFC;
    send();
    wait_valid(n);
    check("pcimm_result", ex_alu_data, 32'h7C);
    @(posedge clk); #1;

    // undefined opcode takes the single-cycle path
    set_instr(5'd31, 5'd1, 32'h1, 5'd2, 32'h2);
    send();
    wait_valid(n);
    check("undef_latency", 32'(n), 32'd2);
    @(posedge clk); #1;

    // randomized traffic with back-pressure, gaps and flushes
    bp_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      send();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
    end
    bp_mode = 1'b0;
    man_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
